// File: rtl/voice_player_fir.sv
// Oscillator back end: phase-accumulated wavetable index, volume scale, [1,3,3,1]/8 FIR smoothing.
// One sample per 256 mclk, registered on the tick edge; no backpressure, valid is a one-cycle pulse.
module voice_player_fir #(
  parameter int CLIP_LEN        = 32,
  parameter int FREQ_RES_BITS   = 16,
  parameter int FRAC_BITS       = 8,
  parameter int VOLUME_BITS     = 4,
  localparam int IDX_W          = $clog2(CLIP_LEN),
  localparam int PHASE_W        = IDX_W + FRAC_BITS
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic [FREQ_RES_BITS-1:0] p_frequency,
  input  logic [VOLUME_BITS-1:0]   volume,
  input  logic signed [15:0]       sample_in,
  output logic [IDX_W-1:0]         player_sample_index,
  output logic signed [15:0]       p_sample_buffer,
  output logic                     valid
);

  logic [7:0]                           div_cnt;
  logic                                 tick;
  logic [PHASE_W-1:0]                   phase;
  logic [PHASE_W-1:0]                   inc;
  logic [FREQ_RES_BITS+PHASE_W-1:0]     freq_ext;
  logic signed [VOLUME_BITS+16:0]       prod;
  logic signed [15:0]                   vol;
  logic signed [15:0]                   t0, t1, t2;
  logic [18:0]                          v_x, t0_x, t1_x, t2_x, acc;
  logic signed [15:0]                   y;
  logic                                 unused_bits;

  assign tick = (div_cnt == 8'hFF);

  // Zero-extend then keep the low PHASE_W bits: covers both narrower and wider increments.
  assign freq_ext = {{PHASE_W{1'b0}}, p_frequency};
  assign inc      = freq_ext[PHASE_W-1:0];

  assign player_sample_index = phase[PHASE_W-1 -: IDX_W];

  // Taking bits above VOLUME_BITS of the signed product is the floor-rounded arithmetic shift.
  assign prod = sample_in * $signed({1'b0, volume});
  assign vol  = prod[VOLUME_BITS +: 16];

  assign v_x  = {{3{vol[15]}}, vol};
  assign t0_x = {{3{t0[15]}}, t0};
  assign t1_x = {{3{t1[15]}}, t1};
  assign t2_x = {{3{t2[15]}}, t2};
  assign acc  = v_x + (t0_x << 1) + t0_x + (t1_x << 1) + t1_x + t2_x;
  assign y    = acc[18:3];

  assign unused_bits = ^{prod[VOLUME_BITS-1:0], prod[VOLUME_BITS+16], acc[2:0],
                         freq_ext[FREQ_RES_BITS+PHASE_W-1:PHASE_W]};

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      div_cnt         <= 8'd0;
      phase           <= '0;
      t0              <= '0;
      t1              <= '0;
      t2              <= '0;
      p_sample_buffer <= '0;
      valid           <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      valid   <= tick;
      if (tick) begin
        phase           <= phase + inc;
        p_sample_buffer <= y;
        t2              <= t1;
        t1              <= t0;
        t0              <= vol;
      end
    end
  end

endmodule

// File: tb/tb_voice_player_fir.sv
// Scoreboard bench for voice_player_fir: a behavioural model pushes expected samples at each tick.
module tb_voice_player_fir;

  logic              mclk = 1'b0;
  logic              rst  = 1'b1;
  logic [15:0]       p_frequency = '0;
  logic [3:0]        volume = '0;
  logic signed [15:0] sample_reg = '0;
  logic signed [15:0] sample_in;
  logic [4:0]        player_sample_index;
  logic signed [15:0] p_sample_buffer;
  logic              valid;

  logic signed [15:0] lut [32];
  bit                use_lut = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  b_cnt;
  logic [12:0] m_phase;
  int          m_t0, m_t1, m_t2;
  int          q_y[$];
  logic [4:0]  q_i[$];

  voice_player_fir dut (
    .mclk                (mclk),
    .rst                 (rst),
    .p_frequency         (p_frequency),
    .volume              (volume),
    .sample_in           (sample_in),
    .player_sample_index (player_sample_index),
    .p_sample_buffer     (p_sample_buffer),
    .valid               (valid)
  );

  always #5 mclk = ~mclk;

  assign sample_in = use_lut ? lut[player_sample_index] : sample_reg;

  // Bench-side sample clock: the next posedge is a tick when b_cnt==255.
  always @(posedge mclk or negedge rst) begin
    if (!rst) b_cnt <= 8'd0;
    else      b_cnt <= b_cnt + 8'd1;
  end

  task automatic model_clear();
    m_phase = '0;
    m_t0 = 0; m_t1 = 0; m_t2 = 0;
    q_y.delete();
    q_i.delete();
  endtask

  task automatic step_model();
    int s, v, acc;
    s = use_lut ? int'(lut[m_phase[12:8]]) : int'(sample_reg);
    v = (s * int'(volume)) >>> 4;
    acc = v + 3 * m_t0 + 3 * m_t1 + m_t2;
    m_phase = m_phase + p_frequency[12:0];
    q_y.push_back(acc >>> 3);
    q_i.push_back(m_phase[12:8]);
    m_t2 = m_t1; m_t1 = m_t0; m_t0 = v;
  endtask

  // Waits for the next tick, feeds the model, and returns what the DUT shows after the tick edge.
  task automatic get_out(output logic signed [15:0] b, output logic [4:0] i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge mclk);
      if (b_cnt == 8'd255) begin ok = 1'b1; break; end
    end
    if (ok) begin
      step_model();
      @(negedge mclk);
      ok = (valid === 1'b1);
    end
    b = p_sample_buffer;
    i = player_sample_index;
  endtask

  task automatic do_reset(output time t_rel);
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge mclk);
    rst = 1'b1;
    t_rel = $time;
  endtask

  task automatic test_reset();
    logic signed [15:0] b; logic [4:0] i; bit ok; time t_rel; int ey; logic [4:0] ei;
    p_frequency = 16'd0; volume = 4'd0; sample_reg = 16'sd0;
    #1 rst = 1'b0;
    model_clear();
    repeat (3) @(negedge mclk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (player_sample_index !== 5'd0) begin errors++; $display("FAIL reset_index got %0d want 0", player_sample_index); end
    checks++; if (p_sample_buffer !== 16'sd0) begin errors++; $display("FAIL reset_buf got %0d want 0", p_sample_buffer); end
    rst = 1'b1;
    t_rel = $time;
    get_out(b, i, ok);
    ey = q_y.pop_front(); ei = q_i.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL reset_first_valid got no pulse want pulse"); end
    checks++; if (($time - t_rel) !== 64'd2560) begin errors++; $display("FAIL reset_latency got %0t want 2560", $time - t_rel); end
    checks++; if (int'(b) !== ey) begin errors++; $display("FAIL reset_first_buf got %0d want %0d", b, ey); end
    checks++; if (i !== ei) begin errors++; $display("FAIL reset_first_index got %0d want %0d", i, ei); end
  endtask

  task automatic test_step();
    logic signed [15:0] b; logic [4:0] i; bit ok; time t_rel; int ey; logic [4:0] ei;
    int steps [5] = '{1920, 7680, 13440, 15360, 15360};
    p_frequency = 16'd256; volume = 4'd15; sample_reg = 16'sd16384;
    do_reset(t_rel);
    for (int k = 0; k < 5; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL step_valid[%0d] got no pulse want pulse", k); end
      checks++; if (int'(b) !== ey) begin errors++; $display("FAIL step_buf_model[%0d] got %0d want %0d", k, b, ey); end
      checks++; if (int'(b) !== steps[k]) begin errors++; $display("FAIL step_buf_const[%0d] got %0d want %0d", k, b, steps[k]); end
      checks++; if (i !== ei) begin errors++; $display("FAIL step_index[%0d] got %0d want %0d", k, i, ei); end
      checks++; if (int'(i) !== k + 1) begin errors++; $display("FAIL step_index_const[%0d] got %0d want %0d", k, i, k + 1); end
    end
    @(negedge mclk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_single_cycle got %b want 0", valid); end
  endtask

  task automatic test_fraction_wrap();
    logic signed [15:0] b; logic [4:0] i; bit ok; int ey; logic [4:0] ei;
    p_frequency = 16'd128;
    for (int k = 0; k < 60; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || i !== ei || int'(b) !== ey) begin
        errors++; $display("FAIL frac_tick[%0d] got idx %0d buf %0d vld %0d want idx %0d buf %0d", k, i, b, ok, ei, ey);
      end
    end
    p_frequency = 16'd8192;
    for (int k = 0; k < 3; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || i !== ei) begin errors++; $display("FAIL alias_index[%0d] got %0d want %0d", k, i, ei); end
    end
  endtask

  task automatic test_mute_negative();
    logic signed [15:0] b; logic [4:0] i; bit ok; int ey; logic [4:0] ei;
    p_frequency = 16'd256; volume = 4'd0;
    for (int k = 0; k < 4; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || int'(b) !== ey || i !== ei) begin errors++; $display("FAIL mute_tick[%0d] got %0d want %0d", k, b, ey); end
    end
    checks++; if (b !== 16'sd0) begin errors++; $display("FAIL mute_zero got %0d want 0", b); end
    sample_reg = -16'sd32768; volume = 4'd15;
    for (int k = 0; k < 5; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || int'(b) !== ey || i !== ei) begin errors++; $display("FAIL neg_tick[%0d] got %0d want %0d", k, b, ey); end
    end
    checks++; if (int'(b) !== -30720) begin errors++; $display("FAIL neg_steady got %0d want -30720", b); end
  endtask

  task automatic test_midperiod_changes();
    logic signed [15:0] b; logic [4:0] i; bit ok; int ey; logic [4:0] ei;
    repeat (100) @(negedge mclk);
    volume = 4'd7; sample_reg = 16'sd1000; p_frequency = 16'd1024;
    #1;
    checks++; if (player_sample_index !== m_phase[12:8]) begin
      errors++; $display("FAIL freq_ignored_now got %0d want %0d", player_sample_index, m_phase[12:8]);
    end
    repeat (50) @(negedge mclk);
    checks++; if (player_sample_index !== m_phase[12:8] || valid !== 1'b0) begin
      errors++; $display("FAIL freq_ignored_mid got %0d want %0d", player_sample_index, m_phase[12:8]);
    end
    for (int k = 0; k < 3; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || int'(b) !== ey || i !== ei) begin
        errors++; $display("FAIL midperiod_tick[%0d] got idx %0d buf %0d want idx %0d buf %0d", k, i, b, ei, ey);
      end
    end
  endtask

  task automatic test_wavetable();
    logic signed [15:0] b; logic [4:0] i; bit ok; int ey; logic [4:0] ei;
    for (int k = 0; k < 32; k++) lut[k] = 16'(k * 1000 - 16000);
    use_lut = 1'b1; p_frequency = 16'd300; volume = 4'd9;
    for (int k = 0; k < 20; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || int'(b) !== ey || i !== ei) begin
        errors++; $display("FAIL lut_tick[%0d] got idx %0d buf %0d want idx %0d buf %0d", k, i, b, ei, ey);
      end
    end
    use_lut = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic signed [15:0] b; logic [4:0] i; bit ok; time t_rel; int ey; logic [4:0] ei;
    p_frequency = 16'd256; volume = 4'd15; sample_reg = 16'sd8000;
    for (int k = 0; k < 10; k++) begin
      get_out(b, i, ok);
      ey = q_y.pop_front(); ei = q_i.pop_front();
      checks++; if (!ok || int'(b) !== ey || i !== ei) begin errors++; $display("FAIL prerst_tick[%0d] got %0d want %0d", k, b, ey); end
    end
    repeat (77) @(negedge mclk);
    rst = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || player_sample_index !== 5'd0 || p_sample_buffer !== 16'sd0) begin
      errors++; $display("FAIL midrst_clear got vld %b idx %0d buf %0d want 0 0 0", valid, player_sample_index, p_sample_buffer);
    end
    model_clear();
    @(negedge mclk);
    rst = 1'b1;
    t_rel = $time;
    get_out(b, i, ok);
    ey = q_y.pop_front(); ei = q_i.pop_front();
    checks++; if (!ok || ($time - t_rel) !== 64'd2560) begin errors++; $display("FAIL midrst_latency got %0t want 2560", $time - t_rel); end
    checks++; if (int'(b) !== ey || i !== ei) begin errors++; $display("FAIL midrst_first got idx %0d buf %0d want idx %0d buf %0d", i, b, ei, ey); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_fraction_wrap();
    test_mute_negative();
    test_midperiod_changes();
    test_wavetable();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
